csi2tx_int_ctrl: RTL and testbench

Interrupt controller for the CSI-2 TX AHB subsystem. Edge-detects the FIFO and packet error status lines, captures them in a sticky W1C status register with per-source mask, and per-source saturating event counters. Drives the interrupt output through a hold-off/coalescing FSM. Sits beside the register interface on the same local-bus CSR port (lb_aout/lb_dout/lb_wrout/lb_adsm/lb_cs); its int_to_ahb output feeds the AHB top-level interrupt pin.

---
 rtl/csi2tx_int_ctrl_pkg.sv | 29 ++
 rtl/csi2tx_int_evt_cnt.sv | 47 ++++
 rtl/csi2tx_int_ctrl.sv | 163 ++++++++++++++++
 tb/tb_csi2tx_int_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/csi2tx_int_ctrl_pkg.sv
// Shared constants for the CSI-2 TX interrupt controller: CSR word offsets,
// event source indices and the interrupt FSM state encoding.
package csi2tx_int_ctrl_pkg;

    localparam logic [31:0] INT_STATUS_OFF = 32'h0000_0000;
    localparam logic [31:0] INT_MASK_OFF   = 32'h0000_0004;
    localparam logic [31:0] INT_RAW_OFF    = 32'h0000_0008;
    localparam logic [31:0] INT_CTRL_OFF   = 32'h0000_000C;
    localparam logic [31:0] EVT_CNT_OFF    = 32'h0000_0010;
    localparam logic [31:0] MAP_END_OFF    = 32'h0000_0014;

    localparam int SRC_SFIFO_FULL        = 0;
    localparam int SRC_SFIFO_ALMOST_FULL = 1;
    localparam int SRC_ASFIFO_FULL       = 2;
    localparam int SRC_DATA_ID_ERROR     = 3;
    localparam int NUM_SRC               = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ASSERT  = 2'b01,
        ST_HOLDOFF = 2'b10
    } int_state_e;

    // True when a base-relative offset lands on one of the five register words.
    function automatic logic offset_mapped(input logic [31:0] off);
        return (off[1:0] == 2'b00) && (off < MAP_END_OFF);
    endfunction

endpackage

// File: rtl/csi2tx_int_evt_cnt.sv
// One event source: registered history for rising-edge detection plus a
// saturating event counter with a synchronous clear.
module csi2tx_int_evt_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             src,
    input  logic             clr,
    output logic             level,
    output logic             rise,
    output logic [CNT_W-1:0] cnt
);

    logic             hist_q, hist_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Edge detect and counter update; a rise that coincides with a clear leaves the count at 1.
    always_comb begin
        hist_d = src;
        rise   = src & ~hist_q;
        cnt_d  = cnt_q;
        if (rise) begin
            if (clr)
                cnt_d = CNT_W'(1);
            else if (cnt_q != {CNT_W{1'b1}})
                cnt_d = cnt_q + CNT_W'(1);
        end else if (clr) begin
            cnt_d = '0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            cnt_q  <= cnt_d;
        end
    end

    assign level = hist_q;
    assign cnt   = cnt_q;

endmodule

// File: rtl/csi2tx_int_ctrl.sv
// CSI-2 TX interrupt controller: sticky W1C status with mask, per-source event
// counters, local-bus CSR port and a hold-off/coalescing interrupt FSM.
module csi2tx_int_ctrl
    import csi2tx_int_ctrl_pkg::*;
#(
    parameter int          HOLDOFF_W = 16,
    parameter int          CNT_W     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0100
) (
    input  logic        clk_sys,
    input  logic        clk_sys_rst,
    input  logic        csr_cs_n,
    input  logic        csr_rd,
    input  logic        csr_wr,
    input  logic [31:0] csr_addr,
    input  logic [31:0] csr_wr_data,
    output logic [31:0] csr_rd_data,
    output logic        ready,
    output logic        ahb_error_flag,
    input  logic        sfifo_full,
    input  logic        sfifo_almost_full,
    input  logic        asfifo_full,
    input  logic        data_id_error,
    output logic        int_to_ahb
);

    logic [NUM_SRC-1:0]   src_vec, src_lvl, rise_vec;
    logic [CNT_W-1:0]     cnt [NUM_SRC];
    logic [NUM_SRC-1:0]   status_q, status_d, mask_q, mask_d;
    logic                 en_q, en_d;
    logic [HOLDOFF_W-1:0] holdoff_q, holdoff_d, timer_q, timer_d;
    int_state_e           state_q, state_d;
    logic                 int_q, int_d, ready_q, ready_d, err_q, err_d;
    logic [31:0]          rd_data_q, rd_data_d, offset, rd_mux;
    logic                 access, mapped, wr_hit, cnt_clr, pending;
    logic                 unused_wdata;

    assign src_vec = {data_id_error, asfifo_full, sfifo_almost_full, sfifo_full};

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        csi2tx_int_evt_cnt #(.CNT_W(CNT_W)) u_evt (
            .clk   (clk_sys),
            .rst   (clk_sys_rst),
            .src   (src_vec[i]),
            .clr   (cnt_clr),
            .level (src_lvl[i]),
            .rise  (rise_vec[i]),
            .cnt   (cnt[i])
        );
    end

    // Address decode for the current strobe.
    always_comb begin
        access  = ~csr_cs_n & (csr_rd | csr_wr);
        offset  = csr_addr - BASE_ADDR;
        mapped  = offset_mapped(offset);
        wr_hit  = ~csr_cs_n & csr_wr & mapped;
        cnt_clr = wr_hit & (offset == EVT_CNT_OFF);
    end

    // Register writes; a status rise overrides a W1C on the same bit.
    always_comb begin
        status_d  = status_q;
        mask_d    = mask_q;
        en_d      = en_q;
        holdoff_d = holdoff_q;
        if (wr_hit && offset == INT_STATUS_OFF)
            status_d = status_q & ~csr_wr_data[NUM_SRC-1:0];
        if (wr_hit && offset == INT_MASK_OFF)
            mask_d = csr_wr_data[NUM_SRC-1:0];
        if (wr_hit && offset == INT_CTRL_OFF) begin
            en_d      = csr_wr_data[0];
            holdoff_d = csr_wr_data[16 +: HOLDOFF_W];
        end
        status_d = status_d | rise_vec;
    end

    // Read mux and access-complete handshake, registered one cycle after the strobe.
    always_comb begin
        rd_mux = '0;
        case (offset)
            INT_STATUS_OFF: rd_mux = 32'(status_q);
            INT_MASK_OFF:   rd_mux = 32'(mask_q);
            INT_RAW_OFF:    rd_mux = 32'(src_lvl);
            INT_CTRL_OFF:   rd_mux = 32'({holdoff_q, 16'h0000}) | 32'(en_q);
            EVT_CNT_OFF:    rd_mux = 32'({cnt[3], cnt[2], cnt[1], cnt[0]});
            default:        rd_mux = '0;
        endcase
        ready_d   = access;
        err_d     = access & ~mapped;
        rd_data_d = (access && csr_rd && mapped) ? rd_mux : 32'h0;
    end

    // Interrupt FSM; the timer counts holdoff-1 down to 0 before returning to IDLE.
    always_comb begin
        pending = en_q & (|(status_q & mask_q));
        state_d = state_q;
        timer_d = timer_q;
        if (!en_q) begin
            state_d = ST_IDLE;
            timer_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pending)
                        state_d = ST_ASSERT;
                end
                ST_ASSERT: begin
                    if (!pending) begin
                        if (holdoff_q == '0) begin
                            state_d = ST_IDLE;
                        end else begin
                            timer_d = holdoff_q - HOLDOFF_W'(1);
                            state_d = ST_HOLDOFF;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    if (timer_q == '0)
                        state_d = ST_IDLE;
                    else
                        timer_d = timer_q - HOLDOFF_W'(1);
                end
                default: state_d = ST_IDLE;
            endcase
        end
        int_d = (state_d == ST_ASSERT);
    end

    // All controller state, synchronously reset.
    always_ff @(posedge clk_sys) begin
        if (clk_sys_rst) begin
            status_q  <= '0;
            mask_q    <= '0;
            en_q      <= 1'b0;
            holdoff_q <= '0;
            timer_q   <= '0;
            state_q   <= ST_IDLE;
            int_q     <= 1'b0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            status_q  <= status_d;
            mask_q    <= mask_d;
            en_q      <= en_d;
            holdoff_q <= holdoff_d;
            timer_q   <= timer_d;
            state_q   <= state_d;
            int_q     <= int_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign unused_wdata   = ^csr_wr_data;
    assign csr_rd_data    = rd_data_q;
    assign ready          = ready_q;
    assign ahb_error_flag = err_q;
    assign int_to_ahb     = int_q;

endmodule

// File: tb/tb_csi2tx_int_ctrl.sv
// Self-checking bench for csi2tx_int_ctrl: directed scenarios followed by a
// randomized phase, compared every cycle against a timestamp-based reference.
module tb_csi2tx_int_ctrl;

   localparam logic [31:0] BASE = 32'h0000_0100;

   logic        clk_sys = 1'b0;
   logic        clk_sys_rst = 1'b1;
   logic        csr_cs_n = 1'b1;
   logic        csr_rd = 1'b0;
   logic        csr_wr = 1'b0;
   logic [31:0] csr_addr = '0;
   logic [31:0] csr_wr_data = '0;
   logic [31:0] csr_rd_data;
   logic        ready;
   logic        ahb_error_flag;
   logic        sfifo_full = 1'b0;
   logic        sfifo_almost_full = 1'b0;
   logic        asfifo_full = 1'b0;
   logic        data_id_error = 1'b0;
   logic        int_to_ahb;

   int n_assert = 0;
   int n_fail   = 0;
   bit chk_on   = 1'b0;

   csi2tx_int_ctrl #(.HOLDOFF_W(16), .CNT_W(8), .BASE_ADDR(BASE)) dut (
      .clk_sys           (clk_sys),
      .clk_sys_rst       (clk_sys_rst),
      .csr_cs_n          (csr_cs_n),
      .csr_rd            (csr_rd),
      .csr_wr            (csr_wr),
      .csr_addr          (csr_addr),
      .csr_wr_data       (csr_wr_data),
      .csr_rd_data       (csr_rd_data),
      .ready             (ready),
      .ahb_error_flag    (ahb_error_flag),
      .sfifo_full        (sfifo_full),
      .sfifo_almost_full (sfifo_almost_full),
      .asfifo_full       (asfifo_full),
      .data_id_error     (data_id_error),
      .int_to_ahb        (int_to_ahb)
   );

   always #5 clk_sys = ~clk_sys;

   // Reference model: registers as plain integers, interrupt coalescing as a
   // "quiet until cycle" timestamp instead of a down-counter.
   logic [3:0]  m_src_q, m_status, m_mask;
   bit          m_en, m_int;
   int          m_hold, m_cnt [4];
   int          m_cyc = 0, m_quiet_end = -1;
   bit          exp_ready, exp_err;
   logic [31:0] exp_rd;

   always @(posedge clk_sys) begin
      logic [3:0]  src, rise;
      logic [31:0] off;
      bit          pend, acc, mapd, clr;
      m_cyc++;
      if (clk_sys_rst) begin
         m_src_q = 0; m_status = 0; m_mask = 0; m_en = 0; m_hold = 0; m_int = 0;
         m_quiet_end = -1; exp_ready = 0; exp_err = 0; exp_rd = 0;
         for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      end else begin
         src  = {data_id_error, asfifo_full, sfifo_almost_full, sfifo_full};
         rise = src & ~m_src_q;
         pend = m_en && ((m_status & m_mask) != 0);
         if (!m_en) begin
            m_int = 0; m_quiet_end = -1;
         end else if (m_int) begin
            if (!pend) begin
               m_int = 0;
               m_quiet_end = m_cyc + m_hold;
            end
         end else if (pend && m_cyc > m_quiet_end) begin
            m_int = 1;
         end
         acc  = !csr_cs_n && (csr_rd || csr_wr);
         off  = csr_addr - BASE;
         mapd = (off < 32'h14) && (off % 4 == 0);
         exp_ready = acc;
         exp_err   = acc && !mapd;
         exp_rd    = 0;
         if (acc && csr_rd && mapd) begin
            case (off)
               32'h00: exp_rd = {28'h0, m_status};
               32'h04: exp_rd = {28'h0, m_mask};
               32'h08: exp_rd = {28'h0, m_src_q};
               32'h0C: exp_rd = (m_hold << 16) | m_en;
               default: exp_rd = (m_cnt[3] << 24) | (m_cnt[2] << 16) | (m_cnt[1] << 8) | m_cnt[0];
            endcase
         end
         clr = 0;
         if (!csr_cs_n && csr_wr && mapd) begin
            case (off)
               32'h00: m_status = m_status & ~csr_wr_data[3:0];
               32'h04: m_mask = csr_wr_data[3:0];
               32'h0C: begin m_en = csr_wr_data[0]; m_hold = int'(csr_wr_data[31:16]); end
               32'h10: clr = 1;
               default: ;
            endcase
         end
         m_status = m_status | rise;
         for (int i = 0; i < 4; i++) begin
            if (clr) m_cnt[i] = 0;
            if (rise[i]) m_cnt[i] = (m_cnt[i] == 255) ? 255 : m_cnt[i] + 1;
         end
         m_src_q = src;
      end
   end

   // One comparison point: count it, and report tag/observed/expected on a miss.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Cycle-by-cycle comparison of every output against the reference.
   always @(negedge clk_sys) begin
      if (chk_on) begin
         checkOutput("int_to_ahb", 32'(int_to_ahb), 32'(m_int));
         checkOutput("ready", 32'(ready), 32'(exp_ready));
         checkOutput("ahb_error_flag", 32'(ahb_error_flag), 32'(exp_err));
         checkOutput("csr_rd_data", csr_rd_data, exp_rd);
      end
   end

   // One CSR access; returns read data sampled in the ready cycle.
   task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] off,
                                input logic [31:0] data, output logic [31:0] rdata);
      @(negedge clk_sys);
      csr_cs_n = 1'b0; csr_rd = rd; csr_wr = wr; csr_addr = BASE + off; csr_wr_data = data;
      @(negedge clk_sys);
      csr_cs_n = 1'b1; csr_rd = 1'b0; csr_wr = 1'b0;
      rdata = csr_rd_data;
      checkOutput("ready_pulse", 32'(ready), 32'h1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   initial begin
      logic [31:0] rdata;
      int          low_count;
      bit          seen_high;

      // Reset held for three cycles
      idle(1);
      chk_on = 1'b1;
      idle(2);
      clk_sys_rst = 1'b0;
      checkOutput("reset_int", 32'(int_to_ahb), 32'h0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1, 0, 32'(i * 4), 0, rdata);
         checkOutput("reset_reg", rdata, 32'h0);
      end

      // Basic interrupt on asfifo_full
      applyStimulus(0, 1, 32'h04, 32'h4, rdata);
      applyStimulus(0, 1, 32'h0C, 32'h1, rdata);
      @(negedge clk_sys); asfifo_full = 1'b1;
      idle(5);
      asfifo_full = 1'b0;
      checkOutput("basic_int_high", 32'(int_to_ahb), 32'h1);
      applyStimulus(1, 0, 32'h00, 0, rdata);
      checkOutput("basic_status", rdata, 32'h4);
      applyStimulus(1, 0, 32'h10, 0, rdata);
      checkOutput("basic_cnt2", rdata, 32'h0001_0000);
      applyStimulus(0, 1, 32'h00, 32'h4, rdata);
      idle(1);
      checkOutput("basic_int_low", 32'(int_to_ahb), 32'h0);

      // Masked source, then unmasking it
      @(negedge clk_sys); data_id_error = 1'b1;
      idle(2);
      data_id_error = 1'b0;
      idle(2);
      applyStimulus(1, 0, 32'h00, 0, rdata);
      checkOutput("masked_status", rdata, 32'h8);
      checkOutput("masked_int", 32'(int_to_ahb), 32'h0);
      applyStimulus(0, 1, 32'h04, 32'hC, rdata);
      idle(1);
      checkOutput("unmasked_int", 32'(int_to_ahb), 32'h1);
      applyStimulus(0, 1, 32'h00, 32'hF, rdata);
      idle(2);

      // Hold-off of 10: 10 cycles in the timer plus one IDLE cycle before re-assert
      applyStimulus(0, 1, 32'h04, 32'h1, rdata);
      applyStimulus(0, 1, 32'h0C, 32'h000A_0001, rdata);
      @(negedge clk_sys); sfifo_full = 1'b1;
      @(negedge clk_sys); sfifo_full = 1'b0;
      idle(2);
      checkOutput("holdoff_first_int", 32'(int_to_ahb), 32'h1);
      applyStimulus(0, 1, 32'h00, 32'h1, rdata);
      low_count = 0;
      seen_high = 1'b0;
      for (int i = 0; i < 40 && !seen_high; i++) begin
         @(negedge clk_sys);
         if (i == 3) sfifo_full = 1'b1;
         if (i == 4) sfifo_full = 1'b0;
         if (int_to_ahb) seen_high = 1'b1;
         else low_count++;
      end
      checkOutput("holdoff_reassert", 32'(seen_high), 32'h1);
      checkOutput("holdoff_low_cycles", 32'(low_count), 32'd11);
      applyStimulus(0, 1, 32'h00, 32'hF, rdata);
      applyStimulus(0, 1, 32'h0C, 32'h1, rdata);
      idle(2);

      // Saturation of cnt1, then a clear racing a rise
      for (int i = 0; i < 300; i++) begin
         @(negedge clk_sys); sfifo_almost_full = 1'b1;
         @(negedge clk_sys); sfifo_almost_full = 1'b0;
      end
      applyStimulus(1, 0, 32'h10, 0, rdata);
      checkOutput("sat_cnt1", {24'h0, rdata[15:8]}, 32'hFF);
      @(negedge clk_sys);
      csr_cs_n = 1'b0; csr_wr = 1'b1; csr_addr = BASE + 32'h10; csr_wr_data = 32'hDEAD_BEEF;
      sfifo_almost_full = 1'b1;
      @(negedge clk_sys);
      csr_cs_n = 1'b1; csr_wr = 1'b0;
      applyStimulus(1, 0, 32'h10, 0, rdata);
      checkOutput("race_cnt", rdata, 32'h0000_0100);
      sfifo_almost_full = 1'b0;

      // Unmapped and misaligned accesses, RO write ignored
      applyStimulus(1, 0, 32'h14, 0, rdata);
      checkOutput("unmapped_err", 32'(ahb_error_flag), 32'h1);
      checkOutput("unmapped_rd", rdata, 32'h0);
      applyStimulus(1, 1, 32'h06, 32'hF, rdata);
      checkOutput("misaligned_err", 32'(ahb_error_flag), 32'h1);
      applyStimulus(0, 1, 32'h08, 32'hF, rdata);
      checkOutput("ro_write_no_err", 32'(ahb_error_flag), 32'h0);

      // W1C on bit0 coincident with a sfifo_full rise: set wins
      applyStimulus(0, 1, 32'h00, 32'hF, rdata);
      @(negedge clk_sys);
      csr_cs_n = 1'b0; csr_wr = 1'b1; csr_addr = BASE; csr_wr_data = 32'h1;
      sfifo_full = 1'b1;
      @(negedge clk_sys);
      csr_cs_n = 1'b1; csr_wr = 1'b0;
      applyStimulus(1, 0, 32'h00, 0, rdata);
      checkOutput("w1c_race_status", rdata, 32'h1);
      sfifo_full = 1'b0;
      applyStimulus(0, 1, 32'h0C, 32'h0, rdata);
      idle(2);
      checkOutput("disabled_int", 32'(int_to_ahb), 32'h0);

      // Randomized traffic with one mid-run reset
      for (int c = 0; c < 600; c++) begin
         @(negedge clk_sys);
         clk_sys_rst = (c >= 300 && c < 302);
         if ($urandom_range(0, 5) == 0) sfifo_full = ~sfifo_full;
         if ($urandom_range(0, 5) == 0) sfifo_almost_full = ~sfifo_almost_full;
         if ($urandom_range(0, 7) == 0) asfifo_full = ~asfifo_full;
         if ($urandom_range(0, 9) == 0) data_id_error = ~data_id_error;
         csr_cs_n = ($urandom_range(0, 2) != 0);
         csr_rd = 1'($urandom_range(0, 1));
         csr_wr = 1'($urandom_range(0, 1));
         csr_addr = BASE + 32'($urandom_range(0, 6)) * 4 + (($urandom_range(0, 9) == 0) ? 32'h1 : 32'h0);
         csr_wr_data = $urandom & 32'h0007_000F;
         if ($urandom_range(0, 3) == 0) csr_wr_data[0] = 1'b1;
      end
      @(negedge clk_sys);
      csr_cs_n = 1'b1; csr_rd = 1'b0; csr_wr = 1'b0; clk_sys_rst = 1'b0;
      idle(3);

      chk_on = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
